rom_dl_sequencer: RTL and testbench



---
 rtl/rom_dl_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: buffers the HPS download stream and steers each byte to
// the SDRAM write ports (req/ack toggle handshake), the PROM RAMs or the DIP
// latches; also owns rom_loaded and the core reset stretcher.
// Ports: clk_sys/reset (sync, active-high); ioctl_* download bus in, ioctl_wait
// out; port1_*/port2_* SDRAM write ports; prom_wr/addr/data PROM write;
// dip_sw DIP bytes; rom_loaded; core_reset.
module rom_dl_sequencer #(
    parameter logic [24:0] SP_BASE      = 25'h10000,
    parameter logic [24:0] PROM_BASE    = 25'h1C000,
    parameter int          PROM_SIZE    = 800,
    parameter int          RESET_CYCLES = 65535
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    output logic        prom_wr,
    output logic [9:0]  prom_addr,
    output logic [7:0]  prom_data,
    output logic [63:0] dip_sw,
    output logic        rom_loaded,
    output logic        core_reset
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [24:0] PROM_END = PROM_BASE + 25'(PROM_SIZE);
    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    // two-entry FIFO of {addr, data, index}
    logic [24:0] fifo_addr  [2];
    logic [7:0]  fifo_data  [2];
    logic [7:0]  fifo_index [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_n;
    logic        ovf;
    logic        wr_prev;
    logic        wr_edge;
    logic        push;
    logic        pop;

    logic [1:0]  state;
    logic        tgt1;
    logic        tgt2;
    logic        done;

    logic [24:0] h_addr;
    logic [7:0]  h_data;
    logic [7:0]  h_index;
    logic        hit1;
    logic        hit2;
    logic        hit_prom;
    logic        hit_dip;
    logic [23:0] sp_off;
    logic [9:0]  prom_off;

    logic        dl_prev;
    logic        dl_rise;
    logic        dl_fall;
    logic        load_pend;
    logic        drained;
    logic [CW-1:0] rst_cnt;

    assign port1_we = ioctl_download;
    assign port2_we = ioctl_download;

    assign wr_edge = ioctl_wr & ~wr_prev & ioctl_download;
    // a full FIFO still accepts a byte when the head retires this cycle
    assign push    = wr_edge & ((count != 2'd2) | pop);
    assign count_n = count + 2'(push) - 2'(pop);

    assign h_addr  = fifo_addr[rd_ptr];
    assign h_data  = fifo_data[rd_ptr];
    assign h_index = fifo_index[rd_ptr];

    assign hit1     = (h_index == 8'd0) && (h_addr < PROM_BASE);
    assign hit2     = hit1 && (h_addr >= SP_BASE);
    assign hit_prom = (h_index == 8'd0) && (h_addr >= PROM_BASE)
                      && (h_addr < PROM_END);
    assign hit_dip  = (h_index == 8'd254) && (h_addr[24:3] == 22'd0);
    assign sp_off   = 24'(h_addr - SP_BASE);
    assign prom_off = 10'(h_addr - PROM_BASE);

    assign done = (!tgt1 || (port1_ack == port1_req))
                  && (!tgt2 || (port2_ack == port2_req));

    // non-SDRAM bytes retire straight out of ISSUE
    assign pop = ((state == S_ISSUE) && !hit1)
                 || ((state == S_WAIT) && done);

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= ioctl_addr;
            fifo_data[wr_ptr]  <= ioctl_dout;
            fifo_index[wr_ptr] <= ioctl_index;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            ovf        <= 1'b0;
            wr_prev    <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            wr_prev    <= ioctl_wr;
            count      <= count_n;
            ioctl_wait <= (count_n == 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            if (wr_edge && !push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            tgt1      <= 1'b0;
            tgt2      <= 1'b0;
            port1_req <= 1'b0;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_req <= 1'b0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
            prom_wr   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            dip_sw    <= '0;
        end else begin
            prom_wr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // entering on the push itself saves a cycle of latency
                    if ((count != 2'd0) || push) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (hit1) begin
                        port1_a   <= h_addr[23:1];
                        port1_ds  <= {h_addr[0], ~h_addr[0]};
                        port1_d   <= {h_data, h_data};
                        port1_req <= ~port1_req;
                        tgt1      <= 1'b1;
                        tgt2      <= hit2;
                        if (hit2) begin
                            // sprite ROM is stored bit-swizzled on port2
                            port2_a   <= {sp_off[23:16], sp_off[13:0],
                                          sp_off[15]};
                            port2_ds  <= {sp_off[14], ~sp_off[14]};
                            port2_d   <= {h_data, h_data};
                            port2_req <= ~port2_req;
                        end
                        state <= S_WAIT;
                    end else begin
                        if (hit_prom) begin
                            prom_wr   <= 1'b1;
                            prom_addr <= prom_off;
                            prom_data <= h_data;
                        end
                        if (hit_dip) begin
                            dip_sw[{h_addr[2:0], 3'b000} +: 8] <= h_data;
                        end
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dl_rise = ioctl_download & ~dl_prev & (ioctl_index == 8'd0);
    assign dl_fall = ~ioctl_download & dl_prev & (ioctl_index == 8'd0);
    assign drained = (state == S_IDLE) && (count == 2'd0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_prev    <= 1'b0;
            load_pend  <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            if (dl_rise) begin
                rom_loaded <= 1'b0;
                load_pend  <= 1'b0;
            end else if (dl_fall || load_pend) begin
                // the flag waits until the last buffered byte has retired
                if (drained) begin
                    rom_loaded <= 1'b1;
                    load_pend  <= 1'b0;
                end else begin
                    load_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !rom_loaded) begin
            rst_cnt <= CW'(RESET_CYCLES);
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    assign core_reset = (rst_cnt != '0);

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: table vectors, hand sequences and a randomized
// download checked against a byte-level reference model.
module tb_rom_dl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        port1_req, port1_ack, port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack, port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        prom_wr;
    logic [9:0]  prom_addr;
    logic [7:0]  prom_data;
    logic [63:0] dip_sw;
    logic        rom_loaded;
    logic        core_reset;

    always #5 clk = ~clk;

    rom_dl_sequencer #(.RESET_CYCLES(16)) dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_d(port2_d), .port2_we(port2_we),
        .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_data(prom_data),
        .dip_sw(dip_sw), .rom_loaded(rom_loaded), .core_reset(core_reset)
    );

    typedef struct {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } xfer_t;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } prom_t;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        n1;
        logic [22:0] a1;
        logic [1:0]  ds1;
        logic        n2;
        logic [22:0] a2;
        logic [1:0]  ds2;
        logic        np;
        logic [9:0]  pa;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat1 = 0, lat2 = 0, c1 = 0, c2 = 0;
    int last_a1 = 0, last_a2 = 0;
    logic p1_prev, p2_prev, a1_prev, a2_prev;

    xfer_t p1_obs[$], p2_obs[$], p1_exp[$], p2_exp[$];
    prom_t prom_obs[$], prom_exp[$];
    int    t_p1[$];
    logic [7:0] dip_exp [8];
    vec_t  vt [12];

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM model: acknowledges each toggle after latN extra cycles
    always @(posedge clk) begin
        if (reset) begin
            port1_ack <= 1'b0;
            port2_ack <= 1'b0;
            c1 <= 0;
            c2 <= 0;
        end else begin
            if (port1_req != port1_ack) begin
                if (c1 >= lat1) begin
                    port1_ack <= port1_req;
                    c1 <= 0;
                end else c1 <= c1 + 1;
            end
            if (port2_req != port2_ack) begin
                if (c2 >= lat2) begin
                    port2_ack <= port2_req;
                    c2 <= 0;
                end else c2 <= c2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            p1_prev = port1_req;
            p2_prev = port2_req;
            a1_prev = port1_ack;
            a2_prev = port2_ack;
        end else begin
            if (port1_req !== p1_prev) begin
                p1_obs.push_back('{port1_a, port1_ds, port1_d});
                t_p1.push_back(cyc);
                p1_prev = port1_req;
            end
            if (port2_req !== p2_prev) begin
                p2_obs.push_back('{port2_a, port2_ds, port2_d});
                p2_prev = port2_req;
            end
            if (port1_ack !== a1_prev) begin
                last_a1 = cyc;
                a1_prev = port1_ack;
            end
            if (port2_ack !== a2_prev) begin
                last_a2 = cyc;
                a2_prev = port2_ack;
            end
            if (prom_wr === 1'b1) prom_obs.push_back('{prom_addr, prom_data});
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference model: where a single download byte must end up
    task automatic expect_byte(input logic [7:0] idx, input logic [24:0] addr,
                               input logic [7:0] data);
        int a;
        int o;
        xfer_t x;
        prom_t p;
        a = int'(addr);
        if (idx == 8'd0) begin
            if (a < 'h1C000) begin
                x.a  = 23'(a / 2);
                x.ds = (a % 2 == 1) ? 2'b10 : 2'b01;
                x.d  = {data, data};
                p1_exp.push_back(x);
                if (a >= 'h10000) begin
                    o = a - 'h10000;
                    x.a = 23'(((o / 65536) % 256) * 32768
                              + (o % 16384) * 2 + (o / 32768) % 2);
                    x.ds = ((o / 16384) % 2 == 1) ? 2'b10 : 2'b01;
                    p2_exp.push_back(x);
                end
            end else if (a < 'h1C000 + 800) begin
                p.a = 10'(a - 'h1C000);
                p.d = data;
                prom_exp.push_back(p);
            end
        end else if (idx == 8'd254 && a < 8) begin
            dip_exp[a] = data;
        end
    endtask

    task automatic clear_obs();
        p1_obs.delete();
        p2_obs.delete();
        prom_obs.delete();
        t_p1.delete();
    endtask

    task automatic compare_all(input string nm);
        check({nm, "_p1_count"}, 64'(p1_obs.size()), 64'(p1_exp.size()));
        for (int i = 0; i < p1_obs.size() && i < p1_exp.size(); i++)
            check({nm, "_p1"}, {p1_obs[i].a, p1_obs[i].ds, p1_obs[i].d},
                  {p1_exp[i].a, p1_exp[i].ds, p1_exp[i].d});
        check({nm, "_p2_count"}, 64'(p2_obs.size()), 64'(p2_exp.size()));
        for (int i = 0; i < p2_obs.size() && i < p2_exp.size(); i++)
            check({nm, "_p2"}, {p2_obs[i].a, p2_obs[i].ds, p2_obs[i].d},
                  {p2_exp[i].a, p2_exp[i].ds, p2_exp[i].d});
        check({nm, "_prom_count"}, 64'(prom_obs.size()),
              64'(prom_exp.size()));
        for (int i = 0; i < prom_obs.size() && i < prom_exp.size(); i++)
            check({nm, "_prom"}, {prom_obs[i].a, prom_obs[i].d},
                  {prom_exp[i].a, prom_exp[i].d});
        p1_exp.delete();
        p2_exp.delete();
        prom_exp.delete();
        clear_obs();
    endtask

    task automatic send(input logic [7:0] idx, input logic [24:0] addr,
                        input logic [7:0] data);
        int k;
        k = 0;
        while (ioctl_wait && k < 300) begin
            step(1);
            k++;
        end
        check("wait_bound", 64'(ioctl_wait), 64'd0);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        step(1);
        ioctl_wr    = 1'b0;
        step(1);
    endtask

    // waits for rom_loaded, then counts cycles until core_reset drops
    task automatic await_release(input string nm);
        int k;
        int n;
        k = 0;
        while (!rom_loaded && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_loaded"}, 64'(rom_loaded), 64'd1);
        n = 0;
        while (core_reset && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_hold"}, 64'(n), 64'd16);
    endtask

    initial begin
        logic [63:0] dip_pk;
        logic        ok;
        int          rl_cyc;
        int          r;
        logic [24:0] ad;
        logic [7:0]  ix;

        vt[0]  = '{8'd0,   25'h00003, 8'h5A, 1, 23'h000001, 2'b10,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[1]  = '{8'd0,   25'h14005, 8'h11, 1, 23'h00A002, 2'b10,
                   1, 23'h00000A, 2'b10, 0, 10'h0};
        vt[2]  = '{8'd0,   25'h1C31F, 8'h3C, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 1, 10'h31F};
        vt[3]  = '{8'd0,   25'h1C320, 8'h77, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[4]  = '{8'd0,   25'h10000, 8'h22, 1, 23'h008000, 2'b01,
                   1, 23'h000000, 2'b01, 0, 10'h0};
        vt[5]  = '{8'd0,   25'h1BFFF, 8'h33, 1, 23'h00DFFF, 2'b10,
                   1, 23'h007FFF, 2'b01, 0, 10'h0};
        vt[6]  = '{8'd0,   25'h1C000, 8'h44, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 1, 10'h000};
        vt[7]  = '{8'd254, 25'h00005, 8'hA7, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[8]  = '{8'd254, 25'h00008, 8'h55, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[9]  = '{8'd3,   25'h00000, 8'h99, 0, 23'h0, 2'b00,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[10] = '{8'd0,   25'h0FFFF, 8'h66, 1, 23'h007FFF, 2'b10,
                   0, 23'h0, 2'b00, 0, 10'h0};
        vt[11] = '{8'd0,   25'h1A000, 8'h5C, 1, 23'h00D000, 2'b01,
                   1, 23'h004001, 2'b01, 0, 10'h0};

        for (int i = 0; i < 8; i++) dip_exp[i] = 8'h00;

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_index = '0;
        step(3);
        reset = 1'b0;
        step(1);
        @(negedge clk);
        check("rst_p1_req", 64'(port1_req), 64'd0);
        check("rst_p2_req", 64'(port2_req), 64'd0);
        check("rst_p1_a", 64'(port1_a), 64'd0);
        check("rst_prom_wr", 64'(prom_wr), 64'd0);
        check("rst_dip", dip_sw, 64'd0);
        check("rst_loaded", 64'(rom_loaded), 64'd0);
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_we", 64'(port1_we), 64'd0);

        // first byte: req must toggle exactly two cycles after the edge
        step(1);
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step(1);
        check("we_follows_dl", 64'(port2_we), 64'd1);
        ioctl_addr = 25'h00003;
        ioctl_dout = 8'h5A;
        ioctl_wr = 1'b1;
        @(posedge clk);
        #1 ioctl_wr = 1'b0;
        @(negedge clk);
        check("lat_n1", 64'(port1_req), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_n2", 64'(port1_req), 64'd1);
        step(10);
        check("lat_retired", 64'(port1_ack), 64'd1);
        check("lat_count", 64'(p1_obs.size()), 64'd1);
        clear_obs();

        lat1 = 2;
        lat2 = 2;
        for (int i = 0; i < 12; i++) begin
            clear_obs();
            send(vt[i].idx, vt[i].addr, vt[i].data);
            step(15);
            check($sformatf("vec%0d_n1", i), 64'(p1_obs.size()),
                  64'(vt[i].n1));
            if (p1_obs.size() == 1 && vt[i].n1)
                check($sformatf("vec%0d_p1", i),
                      {p1_obs[0].a, p1_obs[0].ds, p1_obs[0].d},
                      {vt[i].a1, vt[i].ds1, vt[i].data, vt[i].data});
            check($sformatf("vec%0d_n2", i), 64'(p2_obs.size()),
                  64'(vt[i].n2));
            if (p2_obs.size() == 1 && vt[i].n2)
                check($sformatf("vec%0d_p2", i),
                      {p2_obs[0].a, p2_obs[0].ds, p2_obs[0].d},
                      {vt[i].a2, vt[i].ds2, vt[i].data, vt[i].data});
            check($sformatf("vec%0d_np", i), 64'(prom_obs.size()),
                  64'(vt[i].np));
            if (prom_obs.size() == 1 && vt[i].np)
                check($sformatf("vec%0d_prom", i),
                      {prom_obs[0].a, prom_obs[0].d},
                      {vt[i].pa, vt[i].data});
        end
        check("dip_table", dip_sw, 64'h0000_A700_0000_0000);
        clear_obs();

        // port2 ack 20 cycles behind port1: next byte must wait for it
        lat1 = 0;
        lat2 = 20;
        expect_byte(8'd0, 25'h14005, 8'hAB);
        expect_byte(8'd0, 25'h00002, 8'hCD);
        send(8'd0, 25'h14005, 8'hAB);
        send(8'd0, 25'h00002, 8'hCD);
        step(60);
        ok = (t_p1.size() == 2) && (t_p1[1] > last_a2)
             && (last_a2 - t_p1[0] >= 20);
        check("dual_hold", 64'(ok), 64'd1);
        compare_all("dual");

        // slow acks: FIFO fills, wait asserts, nothing lost
        lat1 = 50;
        lat2 = 0;
        expect_byte(8'd0, 25'h00100, 8'h01);
        expect_byte(8'd0, 25'h00102, 8'h02);
        expect_byte(8'd0, 25'h00104, 8'h03);
        send(8'd0, 25'h00100, 8'h01);
        send(8'd0, 25'h00102, 8'h02);
        @(negedge clk);
        check("wait_hi", 64'(ioctl_wait), 64'd1);
        send(8'd0, 25'h00104, 8'h03);
        step(200);
        check("no_ovf", 64'(dut.ovf), 64'd0);
        compare_all("bp");

        // strobe into a full FIFO is dropped and flagged
        expect_byte(8'd0, 25'h00106, 8'h04);
        expect_byte(8'd0, 25'h00108, 8'h05);
        send(8'd0, 25'h00106, 8'h04);
        send(8'd0, 25'h00108, 8'h05);
        ioctl_addr = 25'h0010A;
        ioctl_dout = 8'h06;
        ioctl_wr = 1'b1;
        step(1);
        ioctl_wr = 1'b0;
        step(1);
        @(negedge clk);
        check("ovf_set", 64'(dut.ovf), 64'd1);
        step(150);
        compare_all("ovf");

        // download ends with two bytes still waiting for acks
        lat1 = 30;
        ioctl_index = 8'd0;
        expect_byte(8'd0, 25'h00200, 8'h10);
        expect_byte(8'd0, 25'h00201, 8'h11);
        send(8'd0, 25'h00200, 8'h10);
        send(8'd0, 25'h00201, 8'h11);
        ioctl_download = 1'b0;
        step(1);
        @(negedge clk);
        check("rl_pending", 64'(rom_loaded), 64'd0);
        check("rl_core_reset", 64'(core_reset), 64'd1);
        await_release("drain");
        rl_cyc = cyc;
        check("rl_after_ack", 64'(rl_cyc > last_a1), 64'd1);
        compare_all("drain");

        // new download clears the flag; reset mid-count restarts the hold
        step(1);
        ioctl_download = 1'b1;
        step(2);
        check("restart_clear", 64'(rom_loaded), 64'd0);
        check("restart_core", 64'(core_reset), 64'd1);
        ioctl_download = 1'b0;
        step(3);
        check("empty_loaded", 64'(rom_loaded), 64'd1);
        step(5);
        check("mid_count", 64'(core_reset), 64'd1);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_mid_loaded", 64'(rom_loaded), 64'd0);
        step(30);
        check("rst_mid_hold", 64'(core_reset), 64'd1);
        check("rst_mid_dip", dip_sw, 64'd0);

        // randomized download against the model
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step(1);
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 6));
            ix = 8'd0;
            case (r)
                0: ad = 25'($urandom_range(0, 'hFFFF));
                1: ad = 25'($urandom_range('h10000, 'h1BFFF));
                2: ad = 25'($urandom_range('h1C000, 'h1C31F));
                3: ad = 25'($urandom_range('h1C31E, 'h1C322));
                4: ad = 25'($urandom_range('h1C320, 'h1FFFFFF));
                5: begin
                    ix = 8'd254;
                    ad = 25'($urandom_range(0, 15));
                end
                default: begin
                    ix = 8'($urandom_range(1, 253));
                    ad = 25'($urandom_range(0, 'hFFFF));
                end
            endcase
            lat1 = int'($urandom_range(0, 6));
            lat2 = int'($urandom_range(0, 6));
            expect_byte(ix, ad, 8'($urandom));
            if (ix == 8'd254 && ad < 25'd8)
                send(ix, ad, dip_exp[ad[2:0]]);
            else if (ix == 8'd0 && ad < 25'h1C000)
                send(ix, ad, p1_exp[$].d[7:0]);
            else if (ix == 8'd0 && ad < 25'h1C320)
                send(ix, ad, prom_exp[$].d);
            else
                send(ix, ad, 8'($urandom));
        end
        ioctl_index = 8'd0;
        step(1);
        ioctl_download = 1'b0;
        step(1);
        await_release("rand");
        compare_all("rand");
        for (int i = 0; i < 8; i++) dip_pk[i*8 +: 8] = dip_exp[i];
        check("rand_dip", dip_sw, dip_pk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
